logic_op_pipe: RTL and testbench
================================

// Module: logic_op_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit with a valid/ready stream interface.
//  - One instance covers the full gate set: AND, OR, NOT, NAND, NOR, XOR, XNOR, PASS, selected per beat by an opcode.
//  - Optional accumulate mode folds each beat into an internal register.
//  - Sits between datapath producers and consumers wherever a registered, back-pressurable logic operation is needed.
// PARAMETERS
//  WIDTH   8  data width of in1, in2, o (>=1)
//  STAGES  2  register stages from input to output (1..4); equals latency in cycles
// PORTS
//  clk       input   1      single clock, rising edge
//  rst       input   1      synchronous, active-high reset
//  in_valid  input   1      input beat valid
//  in_ready  output  1      unit can accept a beat this cycle
//  op        input   3      opcode, sampled with the beat
//  acc_mode  input   1      1: operand A = accumulator instead of in1
//  acc_clr   input   1      clear accumulator (independent of in_valid)
//  in1       input   WIDTH  operand A
//  in2       input   WIDTH  operand B
//  o_valid   output  1      output beat valid
//  o_ready   input   1      consumer accepts the output beat
//  o         output  WIDTH  result
//  o_zero    output  1      o == 0
//  o_parity  output  1      XOR-reduction of o
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all stage valids=0, acc=0, o=0, o_zero=0, o_parity=0.
//    - In-flight beats are discarded; never emitted.
//    - in_ready=1 in the first cycle after reset deasserts.
//  - Opcodes: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS(A). Bitwise, WIDTH bits, no carries.
//  - Accept: a beat is taken when in_valid && in_ready. Result, o_zero and o_parity are computed combinationally and loaded into stage 0.
//  - Later stages only delay the data.
//  - Stall: stage i loads if it is empty OR stage i+1 advances this cycle. The last stage advances when o_ready=1.
//    - in_ready = stage 0 can load.
//    - Full throughput is 1 beat/cycle. Bubbles collapse.
//    - Up to STAGES beats are buffered.
//  - Latency: o_valid rises exactly STAGES cycles after acceptance when there is no back-pressure.
//  - Output hold: o, o_zero and o_parity stay stable while o_valid && !o_ready. Order is preserved.
//  - Accumulator:
//    - When acc_mode=1, A = acc and in1 is ignored.
//    - On an accepted beat with acc_mode=1: acc <= result.
//    - Beats with acc_mode=0 leave acc unchanged.
//  - acc_clr:
//    - acc_clr=1 sets acc <= 0 at the edge.
//    - If it coincides with an accepted acc_mode beat, the beat uses A=0 and acc <= op(0,in2). The clear takes effect first.
//  - op, acc_mode, in1 and in2 are don't-care when in_valid=0.
// STRUCTURE
//  - Package logic_op_pkg holds:
//    - opcode localparams OP_AND..OP_PASS (3-bit)
//    - function logic_op_f(op, a, b) returning WIDTH bits
//  - Sub-module logic_op_stage: one register slice (valid, data, zero, parity, load enable), instantiated STAGES times by generate.
//  - The top level holds the operand mux, accumulator, flag logic and ready chain.
// TESTING (WIDTH=8, STAGES=2)
//  1. Op sweep with in1=F0, in2=AA, ops 0..7, o_ready=1:
//     o = A0,FA,0F,5F,05,5A,A5,F0, each 2 cycles after accept, 1 beat/cycle.
//  2. o_ready=0, stream 4 beats:
//     exactly 2 accepted, then in_ready=0; after o_ready=1 all 4 emerge in order with no loss or duplication.
//  3. acc_clr, then acc_mode=1 XOR with in2=01,02,04:
//     o = 01,03,07 and acc=07.
//  4. acc=07, same-cycle acc_clr + acc_mode OR beat with in2=10:
//     o=10 and acc=10.
//  5. Two beats in flight, rst high for 1 cycle:
//     o_valid=0 and in_ready=1 next cycle, acc=0, dropped beats never appear.
//  6. Flags:
//     AND 0F,F0 -> o=00, o_zero=1, o_parity=0.
//     XOR 01,00 -> o=01, o_zero=0, o_parity=1.

Source files
------------

// File: rtl/logic_op_pkg.sv
// logic_op_pkg: opcode encodings and the bitwise gate function shared by the logic pipe.
package logic_op_pkg;

    localparam int MAX_W = 64;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Evaluated at MAX_W bits; callers zero-extend operands and truncate the result to their width.
    function automatic logic [MAX_W-1:0] logic_op_f(
        input logic [2:0]       op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        return op == OP_AND  ? a & b :
               op == OP_OR   ? a | b :
               op == OP_NOT  ? ~a :
               op == OP_NAND ? ~(a & b) :
               op == OP_NOR  ? ~(a | b) :
               op == OP_XOR  ? a ^ b :
               op == OP_XNOR ? ~(a ^ b) : a;
    endfunction

endpackage

// File: rtl/logic_op_stage.sv
// logic_op_stage: one register slice of the logic pipe holding valid, result and its flags.
module logic_op_stage
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_zero,
    input  logic             up_parity,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             zero,
    output logic             parity
);

    // Payload only moves with a real beat, so a loaded bubble leaves the last value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            data   <= '0;
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data   <= up_data;
                zero   <= up_zero;
                parity <= up_parity;
            end
        end
    end

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: pipelined, back-pressurable bitwise logic unit with optional accumulate mode.
module logic_op_pipe
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_zero,
    output logic             o_parity
);

    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  res;
    logic              accept;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] z;
    logic [STAGES-1:0] p;
    logic [WIDTH-1:0]  d [STAGES];

    // A same-cycle clear wins over the stored accumulator as operand A.
    always_comb begin
        a   = acc_mode ? (acc_clr ? '0 : acc) : in1;
        res = WIDTH'(logic_op_f(op, MAX_W'(a), MAX_W'(in2)));
    end

    always_comb begin
        ld = '0;
        ld[STAGES-1] = !v[STAGES-1] || o_ready;
        for (int i = STAGES - 2; i >= 0; i--)
            ld[i] = !v[i] || ld[i+1];
    end

    assign in_ready = ld[0];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (accept && acc_mode)
            acc <= res;
        else if (acc_clr)
            acc <= '0;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        if (i == 0) begin : g_head
            logic_op_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .load     (ld[0]),
                .up_valid (in_valid),
                .up_data  (res),
                .up_zero  (~|res),
                .up_parity(^res),
                .valid    (v[0]),
                .data     (d[0]),
                .zero     (z[0]),
                .parity   (p[0])
            );
        end else begin : g_tail
            logic_op_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .load     (ld[i]),
                .up_valid (v[i-1]),
                .up_data  (d[i-1]),
                .up_zero  (z[i-1]),
                .up_parity(p[i-1]),
                .valid    (v[i]),
                .data     (d[i]),
                .zero     (z[i]),
                .parity   (p[i])
            );
        end
    end

    assign o_valid  = v[STAGES-1];
    assign o        = d[STAGES-1];
    assign o_zero   = z[STAGES-1];
    assign o_parity = p[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: randomized scoreboard bench for logic_op_pipe with a behavioural gate/accumulator model.
module tb_logic_op_pipe;

    localparam int STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = '0;
    logic       acc_mode = 1'b0;
    logic       acc_clr = 1'b0;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic       o_valid;
    logic       o_ready = 1'b1;
    logic [7:0] o;
    logic       o_zero;
    logic       o_parity;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       p;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    bit         lat_on = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] m_acc = '0;
    logic       held = 1'b0;
    logic [9:0] held_val = '0;

    logic_op_pipe #(.WIDTH(8), .STAGES(STAGES)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op      (op),
        .acc_mode(acc_mode),
        .acc_clr (acc_clr),
        .in1     (in1),
        .in2     (in2),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o       (o),
        .o_zero  (o_zero),
        .o_parity(o_parity)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_op(input int code, input logic [7:0] a, input logic [7:0] b);
        case (code)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Monitor first (outputs of earlier beats), then the model absorbs the beat taken at the coming edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] a;
        logic [7:0] r;
        if (rst) begin
            q.delete();
            m_acc = '0;
            held  = 1'b0;
        end else begin
            chk("acc", dut.acc, m_acc);
            if (held) chk("hold", {o, o_zero, o_parity}, held_val);
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got o=%0h with empty scoreboard (cycle %0d)", o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("o", o, e.d);
                    chk("o_zero", o_zero, e.z);
                    chk("o_parity", o_parity, e.p);
                    if (e.lat) chk("latency", cyc, e.cyc + STAGES);
                end
            end
            held     = o_valid && !o_ready;
            held_val = {o, o_zero, o_parity};
            if (in_valid && in_ready) begin
                a = acc_mode ? (acc_clr ? 8'h00 : m_acc) : in1;
                r = ref_op(int'(op), a, in2);
                q.push_back('{r, r == 8'h00, ($countones(r) % 2) == 1, cyc, lat_on});
                if (acc_mode) m_acc = r;
                else if (acc_clr) m_acc = '0;
            end else if (acc_clr) begin
                m_acc = '0;
            end
        end
    end

    task automatic send(input logic [2:0] c, input logic m, input logic clr,
                        input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        op = c; acc_mode = m; acc_clr = clr; in1 = a; in2 = b; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  k;
        logic took;
        // reset state
        @(negedge clk);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o", o, 0);
        chk("rst_o_zero", o_zero, 0);
        chk("rst_o_parity", o_parity, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // op sweep, full throughput, fixed latency
        lat_on = 1;
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b0, 8'hF0, 8'hAA);
        idle(4);
        lat_on = 0;

        // back-pressure: only STAGES beats fit
        o_ready = 1'b0;
        k = 0;
        in_valid = 1'b1; acc_mode = 1'b0; op = 3'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) begin
                k++;
                op = 3'($urandom); in1 = 8'($urandom); in2 = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("stall_accepts", k, 2);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        @(posedge clk); #1;
        o_ready = 1'b1;
        for (int j = k; j < 4; j++) send(3'($urandom), 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        idle(5);
        chk("stall_drain", q.size(), 0);

        // accumulate XOR chain
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        lat_on = 1;
        send(3'd5, 1'b1, 1'b0, 8'($urandom), 8'h01);
        send(3'd5, 1'b1, 1'b0, 8'($urandom), 8'h02);
        send(3'd5, 1'b1, 1'b0, 8'($urandom), 8'h04);
        idle(4);
        chk("acc_chain", dut.acc, 8'h07);

        // clear coinciding with an accumulate beat
        send(3'd1, 1'b1, 1'b1, 8'($urandom), 8'h10);
        idle(4);
        chk("acc_clr_beat", dut.acc, 8'h10);
        lat_on = 0;

        // reset with beats in flight
        o_ready = 1'b0;
        send(3'd5, 1'b1, 1'b0, 8'($urandom), 8'h55);
        send(3'd1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_o_valid", o_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_acc", dut.acc, 0);
        @(posedge clk); #1;
        o_ready = 1'b1;
        idle(5);
        chk("flush_queue", q.size(), 0);

        // flag corners
        lat_on = 1;
        send(3'd0, 1'b0, 1'b0, 8'h0F, 8'hF0);
        send(3'd5, 1'b0, 1'b0, 8'h01, 8'h00);
        idle(4);
        lat_on = 0;

        // randomized traffic with random back-pressure and clears
        took = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom % 4) != 0;
                op       = 3'($urandom);
                acc_mode = 1'($urandom);
                in1      = 8'($urandom);
                in2      = 8'($urandom);
            end
            acc_clr = ($urandom % 10) == 0;
            o_ready = ($urandom % 4) != 0;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        idle(6);
        chk("final_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
